// File: rtl/manchester_encoder.sv
// -----------------------------------------------------------------------------
// manchester_encoder
//
// Serialises one DATA_WIDTH-bit word per handshake onto a Manchester line.
// A frame is one sync bit (0), then the payload MSB first, then GAP_BITS idle
// bit periods with the line held low. Bit 0 is sent as low-then-high and bit 1
// as high-then-low. Each half-bit lasts R clk cycles. R is the REF value
// captured at the handshake; REF values 0 and 1 are raised to 2.
//
// Ports
//   clk            in   system clock, rising edge
//   globalReset    in   synchronous active-low reset
//   REF[3:0]       in   half-bit period in clk cycles (captured at handshake)
//   txData[W-1:0]  in   payload word, sent MSB first
//   txValid        in   producer has a word on txData
//   txReady        out  encoder accepts a word this cycle (IDLE only)
//   ManchesterCode out  registered serial line
//   txBusy         out  frame or post-frame gap in progress
//   frameDone      out  one-cycle pulse after the last data half-bit
// -----------------------------------------------------------------------------
module manchester_encoder #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  globalReset,
    input  logic [3:0]            REF,
    input  logic [DATA_WIDTH-1:0] txData,
    input  logic                  txValid,
    output logic                  txReady,
    output logic                  ManchesterCode,
    output logic                  txBusy,
    output logic                  frameDone
);

    // Half-bits in the active part of a frame: sync bit plus payload.
    localparam int            HALVES     = 2 * (DATA_WIDTH + 1);
    localparam int            HW         = $clog2(HALVES);
    localparam logic [HW-1:0] HALF_LAST  = HW'(HALVES - 1);

    // Half-bits in the post-frame gap.
    localparam int            GAP_HALVES = 2 * GAP_BITS;
    localparam int            GW         = (GAP_HALVES > 2) ? $clog2(GAP_HALVES) : 1;
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_HALVES > 0) ? GAP_HALVES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        GAP
    } state_t;

    state_t                state;
    logic [3:0]            r_q;        // captured, clamped half-bit period
    logic [3:0]            half_cnt;   // cycles left in the current half-bit
    logic [HW-1:0]         half_idx;   // half-bit index within the active frame
    logic [GW-1:0]         gap_idx;    // half-bit index within the gap
    logic [DATA_WIDTH:0]   shreg;      // MSB is the bit currently on the line
    logic                  ready_q;
    logic [3:0]            ref_clamped;
    logic                  half_end;

    assign ref_clamped = (REF < 4'd2) ? 4'd2 : REF;
    assign half_end    = (half_cnt == 4'd0);

    // ready_q is a pure register (no path from txValid). The reset gate keeps
    // txReady low for the whole time reset is held, including the cycle before
    // the first reset edge.
    assign txReady = ready_q & globalReset;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of the others; blocking here would create
    // order-dependent simulation and mismatch the synthesised flops.
    always_ff @(posedge clk) begin
        if (!globalReset) begin
            state          <= IDLE;
            r_q            <= 4'd2;
            half_cnt       <= 4'd0;
            half_idx       <= '0;
            gap_idx        <= '0;
            shreg          <= '0;
            ready_q        <= 1'b0;
            ManchesterCode <= 1'b0;
            txBusy         <= 1'b0;
            frameDone      <= 1'b0;
        end else begin
            frameDone <= 1'b0;

            case (state)
                IDLE: begin
                    ready_q        <= 1'b1;
                    ManchesterCode <= 1'b0;
                    txBusy         <= 1'b0;
                    if (txValid && ready_q) begin
                        // The first sync half (low) goes out on this edge so
                        // the frame starts on the very next cycle.
                        r_q            <= ref_clamped;
                        half_cnt       <= ref_clamped - 4'd1;
                        half_idx       <= '0;
                        shreg          <= {1'b0, txData};
                        ManchesterCode <= 1'b0;
                        txBusy         <= 1'b1;
                        ready_q        <= 1'b0;
                        state          <= SYNC;
                    end
                end

                SYNC, DATA: begin
                    if (!half_end) begin
                        half_cnt <= half_cnt - 4'd1;
                    end else if (half_idx == HALF_LAST) begin
                        frameDone      <= 1'b1;
                        ManchesterCode <= 1'b0;
                        if (GAP_BITS == 0) begin
                            state   <= IDLE;
                            txBusy  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            state    <= GAP;
                            half_cnt <= r_q - 4'd1;
                            gap_idx  <= '0;
                        end
                    end else begin
                        half_cnt <= r_q - 4'd1;
                        half_idx <= half_idx + 1'b1;
                        if (!half_idx[0]) begin
                            // Second half of the same bit is its complement.
                            ManchesterCode <= ~shreg[DATA_WIDTH];
                        end else begin
                            // First half of the next bit equals the bit value.
                            ManchesterCode <= shreg[DATA_WIDTH-1];
                            shreg          <= {shreg[DATA_WIDTH-1:0], 1'b0};
                            if (state == SYNC) begin
                                state <= DATA;
                            end
                        end
                    end
                end

                GAP: begin
                    ManchesterCode <= 1'b0;
                    if (!half_end) begin
                        half_cnt <= half_cnt - 4'd1;
                    end else if (gap_idx == GAP_LAST) begin
                        state   <= IDLE;
                        txBusy  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        half_cnt <= r_q - 4'd1;
                        gap_idx  <= gap_idx + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_manchester_encoder.sv
// -----------------------------------------------------------------------------
// tb_manchester_encoder
//
// Directed sequence with randomized frames. Expected line waveforms are built
// from the Manchester encoding rules (bit value per half-bit); a bench-side
// decoder recovers the payload from the observed line for loopback checks.
// Outputs are sampled on the falling edge; inputs are driven there too.
// -----------------------------------------------------------------------------
module tb_manchester_encoder;

    localparam int W   = 8;
    localparam int G   = 2;
    localparam int BIG = 1 << 30;

    logic         clk = 1'b0;
    logic         globalReset;
    logic [3:0]   REF;
    logic [W-1:0] txData;
    logic         txValid;
    logic         txReady;
    logic         ManchesterCode;
    logic         txBusy;
    logic         frameDone;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hs_cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    manchester_encoder #(
        .DATA_WIDTH(W),
        .GAP_BITS  (G)
    ) dut (
        .clk           (clk),
        .globalReset   (globalReset),
        .REF           (REF),
        .txData        (txData),
        .txValid       (txValid),
        .txReady       (txReady),
        .ManchesterCode(ManchesterCode),
        .txBusy        (txBusy),
        .frameDone     (frameDone)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp_r(input logic [3:0] ref_in);
        return (ref_in < 4'd2) ? 2 : int'(ref_in);
    endfunction

    // Call at a falling edge. Presents the word and returns just after the
    // rising edge on which the handshake completes.
    task automatic do_handshake(input logic [W-1:0] d, input logic [3:0] ref_in);
        int guard = 0;
        txData  = d;
        REF     = ref_in;
        txValid = 1'b1;
        while (txReady !== 1'b1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_handshake", {31'b0, txReady}, 32'd1);
        @(posedge clk);
        #1 hs_cyc = cyc;
    endtask

    // Checks up to stop_at cycles after the handshake edge against the
    // waveform the encoding rules predict; decodes the observed line too.
    task automatic check_frame(input logic [W-1:0] d, input logic [3:0] ref_in,
                               input int change_at, input bit hold_valid, input int stop_at);
        int   r      = clamp_r(ref_in);
        int   active = (W + 1) * 2 * r;
        int   total  = (W + 1 + G) * 2 * r;
        logic exp_q[$];
        logic seen[$];
        logic [W-1:0] rec;
        int   bad;

        for (int k = 0; k < 2 * (W + 1); k++) begin
            logic b;
            b = (k < 2) ? 1'b0 : d[W - 1 - (k / 2 - 1)];
            for (int c = 0; c < r; c++) exp_q.push_back(b ^ logic'(k % 2));
        end
        for (int c = 0; c < 2 * G * r; c++) exp_q.push_back(1'b0);

        for (int i = 0; i <= total && i < stop_at; i++) begin
            @(negedge clk);
            if (i == 0 && !hold_valid) txValid = 1'b0;
            if (i == change_at) begin
                txData = ~d;
                REF    = ref_in ^ 4'h5;
            end
            if (i < total) begin
                check("line", {31'b0, ManchesterCode}, {31'b0, exp_q[i]});
                check("busy", {31'b0, txBusy}, 32'd1);
                check("ready_while_busy", {31'b0, txReady}, 32'd0);
                seen.push_back(ManchesterCode);
            end else begin
                check("busy_after_gap", {31'b0, txBusy}, 32'd0);
                check("ready_after_gap", {31'b0, txReady}, 32'd1);
                check("line_idle", {31'b0, ManchesterCode}, 32'd0);
            end
            check("frame_done", {31'b0, frameDone}, {31'b0, (i == active)});
        end

        if (stop_at > total) begin
            // Bench-side decoder: mid-point sample of each half-bit.
            bad = 0;
            rec = '0;
            for (int j = 0; j <= W; j++) begin
                logic first_h, second_h;
                first_h  = seen[2 * j * r + r / 2];
                second_h = seen[(2 * j + 1) * r + r / 2];
                if (second_h !== ~first_h) bad++;
                if (j == 0) begin
                    if (first_h !== 1'b0) bad++;
                end else begin
                    rec[W - j] = first_h;
                end
            end
            check("loopback_halves", bad, 32'd0);
            check("loopback_data", {24'b0, rec}, {24'b0, d});
        end
    endtask

    initial begin
        logic [W-1:0] d;
        logic [3:0]   rr;
        int           first_hs;

        globalReset = 1'b0;
        txValid     = 1'b0;
        txData      = '0;
        REF         = 4'd8;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, txReady}, 32'd0);
        check("rst_line", {31'b0, ManchesterCode}, 32'd0);
        check("rst_busy", {31'b0, txBusy}, 32'd0);
        check("rst_done", {31'b0, frameDone}, 32'd0);
        globalReset = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'b0, txReady}, 32'd1);
        check("busy_after_rst", {31'b0, txBusy}, 32'd0);

        // Nominal frame
        do_handshake(8'hA5, 4'd8);
        check_frame(8'hA5, 4'd8, -1, 1'b0, BIG);

        // Loopback words
        do_handshake(8'h00, 4'd8);
        check_frame(8'h00, 4'd8, -1, 1'b0, BIG);
        do_handshake(8'hFF, 4'd8);
        check_frame(8'hFF, 4'd8, -1, 1'b0, BIG);
        do_handshake(8'h3C, 4'd8);
        check_frame(8'h3C, 4'd8, -1, 1'b0, BIG);

        // REF clamp
        do_handshake(8'h80, 4'd0);
        check_frame(8'h80, 4'd0, -1, 1'b0, BIG);
        do_handshake(8'h80, 4'd1);
        check_frame(8'h80, 4'd1, -1, 1'b0, BIG);

        // Back-to-back with txValid held high
        do_handshake(8'h5A, 4'd4);
        first_hs = hs_cyc;
        check_frame(8'h5A, 4'd4, -1, 1'b1, BIG);
        do_handshake(8'hC3, 4'd4);
        check("b2b_spacing", hs_cyc - first_hs, 32'd89);
        check_frame(8'hC3, 4'd4, -1, 1'b0, BIG);

        // Capture: inputs change 3 cycles after handshake
        do_handshake(8'h96, 4'd3);
        check_frame(8'h96, 4'd3, 3, 1'b0, BIG);

        // Randomized frames
        for (int n = 0; n < 6; n++) begin
            d  = W'($urandom);
            rr = 4'($urandom_range(0, 15));
            do_handshake(d, rr);
            check_frame(d, rr, int'($urandom_range(1, 20)), 1'b0, BIG);
        end

        // Reset mid-frame during data bit 4 (halves 10..11, cycles 80..95)
        d = 8'hE7;
        do_handshake(d, 4'd8);
        check_frame(d, 4'd8, -1, 1'b0, 83);
        @(negedge clk);
        globalReset = 1'b0;
        @(negedge clk);
        check("midrst_line", {31'b0, ManchesterCode}, 32'd0);
        check("midrst_busy", {31'b0, txBusy}, 32'd0);
        check("midrst_done", {31'b0, frameDone}, 32'd0);
        check("midrst_ready", {31'b0, txReady}, 32'd0);
        globalReset = 1'b1;
        @(negedge clk);
        check("midrst_ready_after", {31'b0, txReady}, 32'd1);
        begin
            int stray = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (frameDone !== 1'b0 || ManchesterCode !== 1'b0 || txBusy !== 1'b0) stray++;
            end
            check("midrst_no_resume", stray, 32'd0);
        end
        do_handshake(8'h4B, 4'd5);
        check_frame(8'h4B, 4'd5, -1, 1'b0, BIG);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
